// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Raster timing bundle produced by vga_timing_gen and consumed by the
// screensaver pixel path.
//   pixel_en_o     1   one clk_i pulse on the last cycle of each pixel period
//   hsync_o        1   horizontal sync (polarity set by the generator)
//   vsync_o        1   vertical sync (polarity set by the generator)
//   visible_o      1   current position lies inside the active area
//   position_x_o   10  raw horizontal counter
//   position_y_o   10  raw vertical counter
//   frame_start_o  1   pixel_en_o during pixel (0,0)
// master: the timing generator drives every signal.
// slave:  the downstream consumer samples every signal.
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
  logic       pixel_en_o;
  logic       hsync_o;
  logic       vsync_o;
  logic       visible_o;
  logic [9:0] position_x_o;
  logic [9:0] position_y_o;
  logic       frame_start_o;

  modport master (
    output pixel_en_o, hsync_o, vsync_o, visible_o,
           position_x_o, position_y_o, frame_start_o
  );

  modport slave (
    input pixel_en_o, hsync_o, vsync_o, visible_o,
          position_x_o, position_y_o, frame_start_o
  );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator (640x480@60 by default) running from the system
// clock with a pixel-enable divider instead of a derived pixel clock.
//   clk_i   in   system clock
//   rst_ni  in   asynchronous active-low reset
//   vga     vga_timing_gen_if.master  pixel enable, syncs, visible flag,
//           raw x/y position and frame start pulse
// All outputs come straight from flops. The next counter values are decoded
// and registered together with the counters, so syncs and visible change on
// the same edge as the position they describe.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_FRONT      = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BACK       = 48,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_FRONT      = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BACK       = 33,
  parameter bit          SYNC_ACT_LOW = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Boundaries are kept one bit wider than the counters so that a sync end
  // sitting exactly at 1024 still compares correctly.
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic        SYNC_ON    = SYNC_ACT_LOW ? 1'b0 : 1'b1;
  localparam logic        SYNC_OFF   = ~SYNC_ON;
  localparam logic        RST_PIX_EN = (CLK_DIV == 1) ? 1'b1 : 1'b0;

  // Illegal parameter sets are rejected while the design elaborates.
  if (CLK_DIV == 0) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic       pixel_en_q;
  logic       pixel_en_d;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_d;
  logic [9:0] v_d;
  logic       hsync_q;
  logic       vsync_q;
  logic       visible_q;
  logic       frame_start_q;
  logic       hsync_d;
  logic       vsync_d;
  logic       visible_d;
  logic       frame_start_d;

  // Pixel-enable divider. The enable is registered from the next divider
  // value so it is high during the last clk_i of every pixel period. With
  // CLK_DIV of 1 every clk_i is a pixel and no divider state exists.
  if (CLK_DIV > 1) begin : g_div
    localparam int unsigned       DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_d;

    assign div_d      = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    assign pixel_en_d = (div_d == DIV_LAST);

    // Free-running divider, cleared by reset so the raster phase is fixed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_d;
      end
    end
  end else begin : g_no_div
    assign pixel_en_d = 1'b1;
  end

  // Next raster position: the counters only move on edges where the current
  // cycle is the last one of a pixel period; h wraps at the line end and
  // carries into v, which wraps at the frame end.
  always_comb begin
    h_d = h_cnt;
    v_d = v_cnt;
    if (pixel_en_q) begin
      if (h_cnt == H_LAST) begin
        h_d = '0;
        v_d = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_d = h_cnt + 10'd1;
      end
    end
  end

  // Flags for the next position, decoded here so they can be registered on
  // the same edge as the counters themselves.
  always_comb begin
    hsync_d       = ({1'b0, h_d} >= HS_START && {1'b0, h_d} < HS_END) ? SYNC_ON : SYNC_OFF;
    vsync_d       = ({1'b0, v_d} >= VS_START && {1'b0, v_d} < VS_END) ? SYNC_ON : SYNC_OFF;
    visible_d     = ({1'b0, h_d} < H_VIS_END) && ({1'b0, v_d} < V_VIS_END);
    frame_start_d = pixel_en_d && (h_d == '0) && (v_d == '0);
  end

  // Counters and every output flag share one register stage. Reset puts the
  // raster back at (0,0) with syncs inactive and no frame start pending.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pixel_en_q    <= RST_PIX_EN;
      h_cnt         <= '0;
      v_cnt         <= '0;
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      visible_q     <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      pixel_en_q    <= pixel_en_d;
      h_cnt         <= h_d;
      v_cnt         <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      visible_q     <= visible_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.pixel_en_o    = pixel_en_q;
  assign vga.hsync_o       = hsync_q;
  assign vga.vsync_o       = vsync_q;
  assign vga.visible_o     = visible_q;
  assign vga.position_x_o  = h_cnt;
  assign vga.position_y_o  = v_cnt;
  assign vga.frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Bench for vga_timing_gen. Three instances share clock and reset:
//   u_dut_def  default 640x480 timing, CLK_DIV=4, active-low syncs
//   u_dut_4    small raster (15x10), CLK_DIV=4, active-low syncs
//   u_dut_1    small raster (12x8),  CLK_DIV=1, active-high syncs
// Expected outputs come from a counting model: the number of clk_i edges
// since reset release determines pixel index, phase and (x,y) directly.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  typedef struct packed {
    logic       en;
    logic       hs;
    logic       vs;
    logic       vis;
    logic [9:0] x;
    logic [9:0] y;
    logic       fs;
  } exp_t;

  // Small rasters keep full frames short enough to observe many wraps.
  localparam int unsigned S4_DIV = 4;
  localparam int unsigned S4_HV = 8, S4_HF = 2, S4_HS = 3, S4_HB = 2;
  localparam int unsigned S4_VV = 6, S4_VF = 1, S4_VS = 2, S4_VB = 1;
  localparam int unsigned S1_DIV = 1;
  localparam int unsigned S1_HV = 5, S1_HF = 1, S1_HS = 2, S1_HB = 4;
  localparam int unsigned S1_VV = 4, S1_VF = 1, S1_VS = 1, S1_VB = 2;
  localparam int unsigned S4_FRAME = (S4_HV+S4_HF+S4_HS+S4_HB) * (S4_VV+S4_VF+S4_VS+S4_VB) * S4_DIV;
  localparam int unsigned S1_FRAME = (S1_HV+S1_HF+S1_HS+S1_HB) * (S1_VV+S1_VF+S1_VS+S1_VB) * S1_DIV;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen_if vga_def ();
  vga_timing_gen_if vga_4 ();
  vga_timing_gen_if vga_1 ();

  vga_timing_gen u_dut_def (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .vga    (vga_def)
  );

  vga_timing_gen #(
    .CLK_DIV(S4_DIV), .H_VISIBLE(S4_HV), .H_FRONT(S4_HF), .H_SYNC(S4_HS), .H_BACK(S4_HB),
    .V_VISIBLE(S4_VV), .V_FRONT(S4_VF), .V_SYNC(S4_VS), .V_BACK(S4_VB), .SYNC_ACT_LOW(1'b1)
  ) u_dut_4 (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .vga    (vga_4)
  );

  vga_timing_gen #(
    .CLK_DIV(S1_DIV), .H_VISIBLE(S1_HV), .H_FRONT(S1_HF), .H_SYNC(S1_HS), .H_BACK(S1_HB),
    .V_VISIBLE(S1_VV), .V_FRONT(S1_VF), .V_SYNC(S1_VS), .V_BACK(S1_VB), .SYNC_ACT_LOW(1'b0)
  ) u_dut_1 (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .vga    (vga_1)
  );

  exp_t act_def;
  exp_t act_4;
  exp_t act_1;

  assign act_def = {vga_def.pixel_en_o, vga_def.hsync_o, vga_def.vsync_o, vga_def.visible_o,
                    vga_def.position_x_o, vga_def.position_y_o, vga_def.frame_start_o};
  assign act_4   = {vga_4.pixel_en_o, vga_4.hsync_o, vga_4.vsync_o, vga_4.visible_o,
                    vga_4.position_x_o, vga_4.position_y_o, vga_4.frame_start_o};
  assign act_1   = {vga_1.pixel_en_o, vga_1.hsync_o, vga_1.vsync_o, vga_1.visible_o,
                    vga_1.position_x_o, vga_1.position_y_o, vga_1.frame_start_o};

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned edge_cnt = 0;
  int unsigned cyc = 0;
  int unsigned period_checks_4 = 0;
  int unsigned period_checks_1 = 0;

  exp_t q_def[$];
  exp_t q_4[$];
  exp_t q_1[$];

  // Raster state after n clk_i edges since reset release (n=0 is the reset
  // state). Pixel index is n/div, the pixel's last cycle is phase div-1.
  function automatic exp_t model(input int unsigned n, input int unsigned div,
                                 input int unsigned hv, input int unsigned hf,
                                 input int unsigned hs, input int unsigned hb,
                                 input int unsigned vv, input int unsigned vf,
                                 input int unsigned vs, input int unsigned vb,
                                 input bit act_low);
    exp_t e;
    int unsigned ht, vt, pos, x, y;
    bit en, fs, hact, vact;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    if (n == 0) begin
      x  = 0;
      y  = 0;
      en = (div == 1);
      fs = 1'b0;
    end else begin
      pos = (n / div) % (ht * vt);
      x   = pos % ht;
      y   = pos / ht;
      en  = ((n % div) == div - 1);
      fs  = en && (x == 0) && (y == 0);
    end
    hact  = (x >= hv + hf) && (x < hv + hf + hs);
    vact  = (y >= vv + vf) && (y < vv + vf + vs);
    e.en  = en;
    e.hs  = act_low ? !hact : hact;
    e.vs  = act_low ? !vact : vact;
    e.vis = (x < hv) && (y < vv);
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.fs  = fs;
    return e;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("en=%0b hs=%0b vs=%0b vis=%0b x=%0d y=%0d fs=%0b",
                     e.en, e.hs, e.vs, e.vis, e.x, e.y, e.fs);
  endfunction

  task automatic check_output(input string name, input exp_t act, input exp_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got {%s} want {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_value(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Push the expected state of every instance after edge n.
  task automatic push_expected(input int unsigned n);
    q_def.push_back(model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1));
    q_4.push_back(model(n, S4_DIV, S4_HV, S4_HF, S4_HS, S4_HB, S4_VV, S4_VF, S4_VS, S4_VB, 1'b1));
    q_1.push_back(model(n, S1_DIV, S1_HV, S1_HF, S1_HS, S1_HB, S1_VV, S1_VF, S1_VS, S1_VB, 1'b0));
  endtask

  // Run free for a number of clk_i edges, queueing the expected state after
  // each edge for the monitor.
  task automatic apply_stimulus(input int unsigned cycles);
    repeat (cycles) begin
      @(posedge clk);
      edge_cnt++;
      push_expected(edge_cnt);
    end
  endtask

  // Release reset between edges and queue the reset state for the monitor.
  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_ni   = 1'b1;
    edge_cnt = 0;
    push_expected(0);
  endtask

  // Assert reset between edges mid-frame; the outputs must fall back to the
  // reset values without waiting for a clock edge.
  task automatic mid_frame_reset(input int unsigned hold);
    @(negedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    check_output("async_rst_def", act_def, model(0, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1));
    check_output("async_rst_4", act_4,
                 model(0, S4_DIV, S4_HV, S4_HF, S4_HS, S4_HB, S4_VV, S4_VF, S4_VS, S4_VB, 1'b1));
    check_output("async_rst_1", act_1,
                 model(0, S1_DIV, S1_HV, S1_HF, S1_HS, S1_HB, S1_VV, S1_VF, S1_VS, S1_VB, 1'b0));
    repeat (hold) @(posedge clk);
    release_reset();
  endtask

  // Scoreboard monitor: every queued expectation is compared on the falling
  // edge, away from the edge that produced it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_def.size() > 0) begin
        e = q_def.pop_front();
        check_output("sb_def", act_def, e);
      end
      if (q_4.size() > 0) begin
        e = q_4.pop_front();
        check_output("sb_4", act_4, e);
      end
      if (q_1.size() > 0) begin
        e = q_1.pop_front();
        check_output("sb_1", act_1, e);
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Frame start spacing: consecutive pulses without an intervening reset
  // must be exactly one frame of clk_i cycles apart.
  initial begin
    int unsigned last_4, last_1;
    bit valid_4, valid_1;
    valid_4 = 1'b0;
    valid_1 = 1'b0;
    last_4  = 0;
    last_1  = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        valid_4 = 1'b0;
        valid_1 = 1'b0;
      end else begin
        if (vga_4.frame_start_o) begin
          if (valid_4) begin
            check_value("fs_period_4", cyc - last_4, S4_FRAME);
            period_checks_4++;
          end
          last_4  = cyc;
          valid_4 = 1'b1;
        end
        if (vga_1.frame_start_o) begin
          if (valid_1) begin
            check_value("fs_period_1", cyc - last_1, S1_FRAME);
            period_checks_1++;
          end
          last_1  = cyc;
          valid_1 = 1'b1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: a long first segment covers several default-timing lines
  // including the hsync pulse, then randomly sized segments split by
  // mid-frame resets of random length.
  initial begin
    rst_ni = 1'b0;
    repeat (10) @(posedge clk);
    release_reset();
    apply_stimulus(8000);
    for (int seg = 0; seg < 6; seg++) begin
      mid_frame_reset($urandom_range(1, 4));
      apply_stimulus($urandom_range(700, 2500));
    end
    @(negedge clk);
    #1;
    check_value("queues_drained", q_def.size() + q_4.size() + q_1.size(), 0);
    check_value("fs_period_seen_4", (period_checks_4 > 0) ? 1 : 0, 1);
    check_value("fs_period_seen_1", (period_checks_1 > 0) ? 1 : 0, 1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
